// File: rtl/mips_multicycle_control.sv
// Moore controller for the multicycle MIPS datapath: sequences fetch/decode/execute
// for lw, sw, R-type, beq and addi, and parks in HALT on anything it cannot decode.
module mips_multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       PCSrc,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_HALT   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t r_state;
  logic   r_is_sw;   // lw/sw choice latched in DECODE; opcode is not looked at again
  logic   w_funct_ok;
  logic   w_pcwrite, w_branch, w_memwrite, w_irwrite, w_regwrite;

  always_comb begin
    w_funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_funct_ok = 1'b1;
      default: w_funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= state_t'(RESET_STATE);
      r_is_sw <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_is_sw <= (opcode == OP_SW);
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= w_funct_ok ? S_EXEC : S_HALT;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEX;
            default:      r_state <= S_HALT;
          endcase
        end
        S_MEMADR: r_state <= r_is_sw ? S_MEMWR : S_MEMRD;
        S_MEMRD:  r_state <= S_MEMWB;
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB: r_state <= S_FETCH;
        default:  r_state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    w_pcwrite  = 1'b0; w_branch   = 1'b0; w_memwrite = 1'b0;
    w_irwrite  = 1'b0; w_regwrite = 1'b0;
    IorD       = 1'b0; RegDst     = 1'b0; MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0; ALUSrcB    = 2'b00; ALUControl = 3'b000;
    PCSrc      = 1'b0; instr_done = 1'b0; halted     = 1'b0;
    case (r_state)
      S_FETCH:  begin w_irwrite = 1'b1; w_pcwrite = 1'b1; ALUSrcB = 2'b01; ALUControl = 3'b010; end
      S_DECODE: begin ALUSrcB = 2'b11; ALUControl = 3'b010; end
      S_MEMADR, S_ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUControl = 3'b010; end
      S_MEMRD:  IorD = 1'b1;
      S_MEMWB:  begin MemtoReg = 1'b1; w_regwrite = 1'b1; instr_done = 1'b1; end
      S_MEMWR:  begin IorD = 1'b1; w_memwrite = 1'b1; instr_done = 1'b1; end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        case (funct)
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      S_ALUWB:  begin RegDst = 1'b1; w_regwrite = 1'b1; instr_done = 1'b1; end
      S_BRANCH: begin
        ALUSrcA = 1'b1; ALUControl = 3'b110; PCSrc = 1'b1; w_branch = 1'b1; instr_done = 1'b1;
      end
      S_ADDIWB: begin w_regwrite = 1'b1; instr_done = 1'b1; end
      S_HALT:   halted = 1'b1;
      default:  ;
    endcase
  end

  // Write enables are gated by reset so nothing commits during the reset cycle.
  assign PCEn     = rst & (w_pcwrite | (w_branch & zero));
  assign MemWrite = rst & w_memwrite;
  assign IRWrite  = rst & w_irwrite;
  assign RegWrite = rst & w_regwrite;
  assign state    = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed cycle table plus random instruction
// streams checked against a per-instruction state-sequence model.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       PCSrc, instr_done, halted;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .state(state),
    .instr_done(instr_done), .halted(halted)
  );

  typedef struct packed {
    logic pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;
    logic pcsrc, done, hlt;
  } ctl_t;

  ctl_t act;
  assign act = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUControl, PCSrc, instr_done, halted};

  typedef struct {
    logic rst; logic [5:0] op, fn; logic z; logic [3:0] st;
    logic pcen, rw, mw, done, hlt;
  } vec_t;

  vec_t tbl[$];
  int total = 0, bad = 0;

  function automatic bit funct_legal(logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] fn);
    case (fn)
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2a: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Control outputs each state should show, straight from the state descriptions.
  function automatic ctl_t model(int st, bit rn, bit z, logic [5:0] fn);
    ctl_t c = '0;
    case (st)
      0:  begin c.pcen = 1; c.irwrite = 1; c.alusrcb = 2'b01; c.aluctl = 3'b010; end
      1:  begin c.alusrcb = 2'b11; c.aluctl = 3'b010; end
      2, 9: begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluctl = 3'b010; end
      3:  c.iord = 1;
      4:  begin c.memtoreg = 1; c.regwrite = 1; c.done = 1; end
      5:  begin c.iord = 1; c.memwrite = 1; c.done = 1; end
      6:  begin c.alusrca = 1; c.aluctl = alu_of(fn); end
      7:  begin c.regdst = 1; c.regwrite = 1; c.done = 1; end
      8:  begin c.alusrca = 1; c.aluctl = 3'b110; c.pcsrc = 1; c.done = 1; c.pcen = z; end
      10: begin c.regwrite = 1; c.done = 1; end
      11: c.hlt = 1;
      default: ;
    endcase
    if (!rn) begin c.pcen = 0; c.memwrite = 0; c.irwrite = 0; c.regwrite = 0; end
    return c;
  endfunction

  task automatic add(logic r, logic [5:0] op, logic [5:0] fn, logic z, logic [3:0] st,
                     logic pcen, logic rw, logic mw, logic done, logic hlt);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.z = z; v.st = st;
    v.pcen = pcen; v.rw = rw; v.mw = mw; v.done = done; v.hlt = hlt;
    tbl.push_back(v);
  endtask

  task automatic chk_bit(string nm, logic a, logic e);
    total++;
    if (a !== e) begin bad++; $display("FAIL %s: got %b want %b", nm, a, e); end
  endtask

  task automatic chk_core(string nm, int est, logic rn, logic z, logic [5:0] fn);
    ctl_t e;
    e = model(est, rn, z, fn);
    total++;
    if (state !== est[3:0]) begin
      bad++; $display("FAIL %s state: got %0d want %0d", nm, state, est);
    end
    total++;
    if (act !== e) begin
      bad++; $display("FAIL %s ctl (st %0d): got %h want %h", nm, est, act, e);
    end
  endtask

  initial begin
    // cycle-by-cycle directed table; each row's inputs steer the next edge
    add(0, 6'h23, 6'h00, 0, 0, 0, 0, 0, 0, 0);                // reset held in FETCH
    add(1, 6'h23, 6'h00, 0, 0, 1, 0, 0, 0, 0);                // lw
    add(1, 6'h23, 6'h00, 0, 1, 0, 0, 0, 0, 0);
    add(1, 6'h23, 6'h00, 0, 2, 0, 0, 0, 0, 0);
    add(1, 6'h23, 6'h00, 0, 3, 0, 0, 0, 0, 0);
    add(1, 6'h23, 6'h00, 0, 4, 0, 1, 0, 1, 0);
    add(1, 6'h2b, 6'h00, 1, 0, 1, 0, 0, 0, 0);                // sw
    add(1, 6'h2b, 6'h00, 1, 1, 0, 0, 0, 0, 0);
    add(1, 6'h00, 6'h22, 1, 2, 0, 0, 0, 0, 0);                // opcode change ignored
    add(1, 6'h00, 6'h22, 1, 5, 0, 0, 1, 1, 0);
    add(1, 6'h00, 6'h22, 0, 0, 1, 0, 0, 0, 0);                // R sub
    add(1, 6'h00, 6'h22, 0, 1, 0, 0, 0, 0, 0);
    add(1, 6'h00, 6'h22, 0, 6, 0, 0, 0, 0, 0);
    add(1, 6'h00, 6'h2a, 0, 7, 0, 1, 0, 1, 0);
    add(1, 6'h00, 6'h2a, 0, 0, 1, 0, 0, 0, 0);                // R slt
    add(1, 6'h00, 6'h2a, 0, 1, 0, 0, 0, 0, 0);
    add(1, 6'h00, 6'h2a, 0, 6, 0, 0, 0, 0, 0);
    add(1, 6'h04, 6'h00, 0, 7, 0, 1, 0, 1, 0);
    add(1, 6'h04, 6'h00, 0, 0, 1, 0, 0, 0, 0);                // beq taken
    add(1, 6'h04, 6'h00, 0, 1, 0, 0, 0, 0, 0);
    add(1, 6'h04, 6'h00, 1, 8, 1, 0, 0, 1, 0);
    add(1, 6'h04, 6'h00, 0, 0, 1, 0, 0, 0, 0);                // beq not taken
    add(1, 6'h04, 6'h00, 0, 1, 0, 0, 0, 0, 0);
    add(1, 6'h08, 6'h00, 0, 8, 0, 0, 0, 1, 0);
    add(1, 6'h08, 6'h00, 0, 0, 1, 0, 0, 0, 0);                // addi
    add(1, 6'h08, 6'h00, 0, 1, 0, 0, 0, 0, 0);
    add(1, 6'h08, 6'h00, 0, 9, 0, 0, 0, 0, 0);
    add(1, 6'h23, 6'h00, 0, 10, 0, 1, 0, 1, 0);
    add(1, 6'h23, 6'h00, 0, 0, 1, 0, 0, 0, 0);                // lw, reset in MEMRD
    add(1, 6'h23, 6'h00, 0, 1, 0, 0, 0, 0, 0);
    add(1, 6'h23, 6'h00, 0, 2, 0, 0, 0, 0, 0);
    add(0, 6'h23, 6'h00, 0, 3, 0, 0, 0, 0, 0);
    add(1, 6'h3f, 6'h00, 0, 0, 1, 0, 0, 0, 0);                // back in FETCH, no writeback
    add(1, 6'h3f, 6'h00, 0, 1, 0, 0, 0, 0, 0);                // illegal opcode
    for (int i = 0; i < 10; i++) add(1, 6'h3f, 6'h20, i[0], 11, 0, 0, 0, 0, 1);
    add(0, 6'h00, 6'h00, 1, 11, 0, 0, 0, 0, 1);
    add(1, 6'h00, 6'h00, 0, 0, 1, 0, 0, 0, 0);                // R with funct 000000
    add(1, 6'h00, 6'h00, 0, 1, 0, 0, 0, 0, 0);
    add(1, 6'h00, 6'h00, 1, 11, 0, 0, 0, 0, 1);
    add(0, 6'h00, 6'h00, 1, 11, 0, 0, 0, 0, 1);

    rst = 1'b0;
    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; opcode = tbl[i].op; funct = tbl[i].fn; zero = tbl[i].z;
      #1;
      chk_core($sformatf("row%0d", i), int'(tbl[i].st), tbl[i].rst, tbl[i].z, tbl[i].fn);
      chk_bit($sformatf("row%0d PCEn", i), PCEn, tbl[i].pcen);
      chk_bit($sformatf("row%0d RegWrite", i), RegWrite, tbl[i].rw);
      chk_bit($sformatf("row%0d MemWrite", i), MemWrite, tbl[i].mw);
      chk_bit($sformatf("row%0d instr_done", i), instr_done, tbl[i].done);
      chk_bit($sformatf("row%0d halted", i), halted, tbl[i].hlt);
    end

    // random instruction stream; the last table row reset us, so FETCH is next
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op, fn;
      int seq[$];
      bit aborted;
      case ($urandom_range(0, 6))
        0: op = 6'h23; 1: op = 6'h2b; 2, 3: op = 6'h00; 4: op = 6'h04; 5: op = 6'h08;
        default: op = 6'($urandom);
      endcase
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom)
         : (6'h20 | (6'($urandom_range(0, 3)) << 1) | 6'($urandom_range(0, 1)) * 6'h0a);
      case (op)
        6'h23: seq = {0, 1, 2, 3, 4};
        6'h2b: seq = {0, 1, 2, 5};
        6'h00: seq = funct_legal(fn) ? {0, 1, 6, 7} : {0, 1, 11, 11, 11};
        6'h04: seq = {0, 1, 8};
        6'h08: seq = {0, 1, 9, 10};
        default: seq = {0, 1, 11, 11, 11};
      endcase
      aborted = 0;
      foreach (seq[k]) begin
        bit rn;
        @(negedge clk);
        rn = ($urandom_range(0, 15) != 0);
        if (seq[k] == 11 && k == seq.size() - 1) rn = 0;  // leave HALT
        rst = rn; zero = 1'($urandom);
        opcode = (seq[k] == 1) ? op : 6'($urandom);
        funct  = (seq[k] == 1 || seq[k] == 6) ? fn : 6'($urandom);
        #1;
        chk_core($sformatf("rnd%0d.%0d", n, k), seq[k], rn, zero, funct);
        if (!rn) begin aborted = 1; break; end
      end
      if (aborted) continue;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore state-machine controller that sequences the 32-bit multicycle MIPS datapath (`dataPath`).
- Drives every control input of the datapath: PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc.
- Decodes opcode/funct from the instruction register and the ALU zero flag.
- Supports lw, sw, R-type (add/sub/and/or/slt), beq and addi; halts on anything else.

Parameters:
- RESET_STATE, 4'd0: state encoding entered on reset (FETCH); the bench does not override it.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-low reset
- opcode  input  6  Instr[31:26] from the IR
- funct  input  6  Instr[5:0] from the IR
- zero  input  1  ALU zero flag of the current cycle
- PCEn  output  1  PC write enable
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  memory write enable
- IRWrite  output  1  instruction register write enable
- RegDst  output  1  register-file write address select: 0=rt, 1=rd
- MemtoReg  output  1  register-file write data select: 0=ALUOut, 1=Data
- RegWrite  output  1  register-file write enable
- ALUSrcA  output  1  ALU operand A select: 0=PC, 1=A
- ALUSrcB  output  2  ALU operand B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- ALUControl  output  3  ALU operation: 010=add, 110=sub, 000=and, 001=or, 111=slt
- PCSrc  output  1  PC source: 0=ALUResult, 1=ALUOut
- state  output  4  current state (debug)
- instr_done  output  1  one-cycle pulse in the last state of each instruction
- halted  output  1  high while in HALT

Behaviour:
- Reset: rst low at a rising edge loads state=FETCH. While rst is low, PCEn, MemWrite, IRWrite and RegWrite are forced 0 combinationally. All other outputs follow the FETCH decode.
- Outputs are decoded from state only, except PCEn = PCWrite | (Branch & zero). Any output not listed for a state is 0.
- States and encodings:
  - FETCH(0): IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=0, IRWrite=1, PCWrite=1. Next: DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut). Next by opcode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXECUTE (legal funct) or HALT
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - otherwise -> HALT
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD(3): IorD=1. Next: MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next: FETCH.
  - MEMWR(5): IorD=1, MemWrite=1, instr_done=1. Next: FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUControl from funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - Next: ALUWB.
  - ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=1, Branch=1, instr_done=1. Next: FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next: ADDIWB.
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next: FETCH.
  - HALT(11): halted=1, all enables 0. Stays in HALT until reset.
- Unused encodings 12..15 go to HALT on the next edge.
- Latency in cycles, FETCH through last state: lw 5, sw 4, R-type 4, beq 3, addi 4.
- Reset mid-instruction: state returns to FETCH on that edge. No write enable is asserted in the reset cycle. No partial writeback completes afterwards.
- opcode/funct are sampled only in DECODE and EXECUTE (IR is stable after FETCH). Changes at other times are ignored.

Test Plan:
- lw: opcode=100011 after reset -> states 0,1,2,3,4,0.
  - FETCH: IRWrite=PCEn=1, ALUSrcB=01, ALUControl=010.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: IorD=1.
  - MEMWB: RegWrite=MemtoReg=1, RegDst=0, instr_done=1.
- sw: opcode=101011 -> states 0,1,2,5,0. MemWrite=1 and IorD=1 in state 5 only.
- R-type: opcode=000000, funct=100010 -> EXECUTE with ALUControl=110 and ALUSrcB=00, then ALUWB with RegDst=1, RegWrite=1. Repeat with funct=101010 -> ALUControl=111.
- beq: opcode=000100.
  - zero=1 -> PCEn=1, PCSrc=1 in BRANCH, 3 cycles total.
  - zero=0 -> PCEn=0 in BRANCH, and FETCH follows.
- Illegal opcode 111111 (or R-type funct=000000) -> HALT after DECODE; halted=1 and enables 0 held for 10 cycles. rst=0 -> FETCH.
- Reset mid-operation: rst=0 during MEMRD of lw -> next state FETCH, RegWrite never 1. rst=0 held at a rising edge while in FETCH -> PCEn=IRWrite=0 that cycle.
